// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory and queues {pc, instr} for decode.
// Latency: a word fetched in cycle N is presented on out_* in cycle N+1; sustains 1 instr/cycle.
// Backpressure: out_valid/out_ready; when the queue is full and decode stalls, the PC and imem_addr hold.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   imem_addr / imem_rdata   combinational instruction-memory read port (addr = PC)
//   redirect_valid/_pc       flush-and-redirect from execute (low two target bits are dropped)
//   out_valid/out_ready      decode handshake; out_instr/out_pc/out_pc_plus4 carry the head entry
//   misalign_err             one-cycle pulse after a redirect whose target had bits [1:0] != 0
//   fetch_count              instructions enqueued since reset (wraps)

// Generic synchronous FIFO with a flush that clears occupancy and pointers.
// Latency: pushed data is visible at the head on the cycle after the push.
// Backpressure: the caller must only push when not full, or when also popping.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_eff;
    logic          pop_eff;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_eff  = pop & ~empty;
    // A push into a full FIFO is only legal because the head leaves in the same cycle.
    assign push_eff = push & (~full | pop_eff);
    assign head_dat = storage[rd_ptr];

    // Storage is not reset: the top masks the head whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_eff && !rst && !flush) begin
            storage[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_ent_t;

    logic [XLEN-1:0] pc;
    logic            fifo_full;
    logic            fifo_empty;
    logic            deq;
    logic            enq;
    fetch_ent_t      push_ent;
    fetch_ent_t      head_ent;

    assign imem_addr = pc;
    assign out_valid = ~fifo_empty;
    assign deq       = out_valid & out_ready;
    // A redirect squashes the word read this cycle; otherwise fetch whenever a slot is
    // free now or is being freed by decode in the same cycle.
    assign enq       = ~redirect_valid & (~fifo_full | deq);

    assign push_ent.pc    = pc;
    assign push_ent.instr = imem_rdata;

    fetch_fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (enq),
        .push_dat (push_ent),
        .pop      (deq),
        .head_dat (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head fields read as zero while empty so stale storage never leaks to decode.
    always_comb begin
        out_instr    = '0;
        out_pc       = '0;
        out_pc_plus4 = '0;
        if (out_valid) begin
            out_instr    = head_ent.instr;
            out_pc       = head_ent.pc;
            out_pc_plus4 = head_ent.pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= XLEN'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (enq) begin
            pc <= pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid & (|redirect_pc[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (enq) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, backpressure, redirects, PC wrap, mid-stream reset.
// A second instance starts near the top of the address space to exercise PC wrap-around.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc_plus4, b_count;
    logic        b_valid, b_misalign;
    logic        b_ready = 1'b1;
    logic        b_redirect = 1'b0;
    logic [31:0] b_redirect_pc = 32'h0;

    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[11:2]];
    assign b_rdata    = mem[b_addr[11:2]];

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .redirect_valid(b_redirect), .redirect_pc(b_redirect_pc),
        .out_valid(b_valid), .out_ready(b_ready), .out_instr(b_instr),
        .out_pc(b_pc), .out_pc_plus4(b_pc_plus4),
        .misalign_err(b_misalign), .fetch_count(b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, out_instr, 32'hA000_0000 | (pc >> 2));
        check({tag, ".pc4"}, out_pc_plus4, pc + 32'd4);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset held two cycles.
        step(); step();
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.instr", out_instr, 32'd0);
        check("rst.pc", out_pc, 32'd0);
        check("rst.pc4", out_pc_plus4, 32'd0);
        check("rst.addr", imem_addr, 32'd0);
        check("rst.cnt", fetch_count, 32'd0);
        check("rst.mis", {31'b0, misalign_err}, 32'd0);
        check("rst.wrap_addr", b_addr, 32'hFFFF_FFF8);

        // Streaming with out_ready high: one instruction per cycle.
        rst = 1'b0;
        step();
        check_head("s0", 32'h0);
        check("s0.cnt", fetch_count, 32'd1);
        check("w0.pc", b_pc, 32'hFFFF_FFF8);
        check("w0.instr", b_instr, 32'hA000_03FE);
        step();
        check_head("s1", 32'h4);
        check("w1.pc", b_pc, 32'hFFFF_FFFC);
        check("w1.pc4", b_pc_plus4, 32'h0);
        step();
        check_head("s2", 32'h8);
        check("w2.pc", b_pc, 32'h0);
        check("w2.instr", b_instr, 32'hA000_0000);
        step();
        check_head("s3", 32'hC);
        check("s3.cnt", fetch_count, 32'd4);

        // Backpressure from a fresh reset: FIFO fills to two, PC stalls at 8.
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_head("bp", 32'h0);
        check("bp.addr", imem_addr, 32'h8);
        check("bp.cnt", fetch_count, 32'd2);
        out_ready = 1'b1;
        step();
        check_head("bp1", 32'h4);
        check("bp1.addr", imem_addr, 32'hC);

        // FIFO now holds pc 4,8: redirect to 0x40 while decode stalls.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        check("rd.valid", {31'b0, out_valid}, 32'd0);
        check("rd.instr", out_instr, 32'd0);
        check("rd.addr", imem_addr, 32'h40);
        check("rd.mis", {31'b0, misalign_err}, 32'd0);
        redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        check_head("rd1", 32'h40);
        step();
        check_head("rd2", 32'h44);

        // Misaligned redirect: target 0x46 fetches from 0x44.
        redirect_valid = 1'b1; redirect_pc = 32'h46;
        step();
        check("mis.err", {31'b0, misalign_err}, 32'd1);
        check("mis.addr", imem_addr, 32'h44);
        check("mis.valid", {31'b0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check("mis.clr", {31'b0, misalign_err}, 32'd0);
        check_head("mis1", 32'h44);
        check("mis.cnt", fetch_count, 32'd6);

        // Fill the FIFO, then reset mid-stream.
        out_ready = 1'b0;
        step(); step();
        check_head("full", 32'h44);
        check("full.addr", imem_addr, 32'h4C);
        rst = 1'b1;
        step();
        check("mrst.valid", {31'b0, out_valid}, 32'd0);
        check("mrst.cnt", fetch_count, 32'd0);
        check("mrst.addr", imem_addr, 32'h0);

        // Back-to-back redirects: the second (misaligned) one wins.
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        check("bb1.addr", imem_addr, 32'h80);
        redirect_pc = 32'h103;
        step();
        check("bb2.addr", imem_addr, 32'h100);
        check("bb2.valid", {31'b0, out_valid}, 32'd0);
        check("bb2.mis", {31'b0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        step();
        check_head("bb3", 32'h100);
        check("bb3.mis", {31'b0, misalign_err}, 32'd0);
        check("bb3.cnt", fetch_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
